bus_clock_generator: RTL and testbench
======================================

// Module: bus_clock_generator
// PURPOSE
//  Drives a bus clock line whose edges stay synchronous to sys_clk.
//  It produces a requested number of full bus clock periods with a programmable half-period.
//  It also produces one-cycle rise/fall strobes aligned with each transition.
//  Sits on the driving side of an interface: the master-side counterpart of edge detection on the sampled side.
// PARAMETERS
//  HALF_PERIOD  4  sys_clk cycles per bus clock half-period; legal range >= 1
//  IDLE_LEVEL   0  bus_clk level when not busy; 0 = rise first, 1 = fall first
//  CNT_WIDTH    8  width of num_cycles; max request is 2^CNT_WIDTH-1 periods
// PORTS
//  sys_clk     in   1          system clock, all logic on posedge
//  sys_rst     in   1          asynchronous, active-high reset
//  start       in   1          request a burst; sampled on posedge
//  num_cycles  in   CNT_WIDTH  full bus clock periods to generate; latched on accept
//  abort       in   1          terminate burst early; sampled on posedge
//  bus_clk     out  1          generated bus clock, registered
//  rise_edge   out  1          high for exactly the first sys_clk cycle bus_clk is 1 after a 0->1 toggle
//  fall_edge   out  1          high for exactly the first sys_clk cycle bus_clk is 0 after a 1->0 toggle
//  busy        out  1          burst in progress
//  done        out  1          one-cycle pulse on normal burst completion
// BEHAVIOUR
//  Reset (async, immediate):
//   - bus_clk=IDLE_LEVEL; rise_edge=fall_edge=busy=done=0; FSM=IDLE; counters cleared.
//   - Mid-burst reset truncates the burst; no strobe is produced for the forced return to idle.
//  FSM states are IDLE and RUN; all outputs are registered.
//  IDLE:
//   - Accept when start=1, abort=0, num_cycles!=0, sampled at edge T0.
//   - At T0: busy<=1, latch N=num_cycles, half-counter<=0, toggle-counter<=0, go to RUN.
//   - start with num_cycles==0 is ignored: no busy, no done.
//  RUN:
//   - Half-counter counts 0..HALF_PERIOD-1 and wraps to 0.
//   - bus_clk toggles at edges T0+k*HALF_PERIOD, k=1..2N.
//   - Odd k moves bus_clk away from IDLE_LEVEL; even k returns it to IDLE_LEVEL.
//   - Each toggle registers the matching strobe (rise_edge or fall_edge) at the same edge; strobes clear at the next edge.
//  Completion:
//   - At toggle 2N: bus_clk=IDLE_LEVEL, busy<=0, done<=1 for one cycle, go to IDLE.
//   - A start in the done cycle is accepted (back-to-back).
//   - The first toggle of the next burst is >= HALF_PERIOD cycles later, which guarantees the idle half-period.
//  start while busy: ignored; num_cycles is not re-sampled.
//  abort while busy, at the next edge:
//   - bus_clk<=IDLE_LEVEL; busy<=0; done stays 0; go to IDLE.
//   - If bus_clk was not at IDLE_LEVEL, the matching strobe fires for that return edge.
//  abort while idle: no effect. abort and start in the same idle cycle: abort wins, start is dropped.
//  Widths:
//   - Half-counter is $clog2(HALF_PERIOD) bits, min 1.
//   - Toggle counter is CNT_WIDTH+1 bits; compare against {N,1'b0} without overflow.
//  HALF_PERIOD=1: bus_clk toggles every sys_clk cycle; strobes may be high on consecutive cycles, alternating rise/fall.
//  Invariants:
//   - rise_edge and fall_edge are never high together.
//   - Strobes are only high while busy, on the completion edge, or on the abort edge.
// TESTING
//  - HP=2, IDLE=0, N=2, start at T0 -> bus_clk 1 on T0+2..3 and T0+6..7, 0 elsewhere.
//    rise at T0+2 and T0+6; fall at T0+4 and T0+8; busy T0..T0+7; done only at T0+8.
//  - N=0 with start -> bus_clk, busy, done and strobes all stay 0 for 20 cycles.
//  - HP=4, N=3, abort while bus_clk=1 -> next edge: bus_clk=0, fall_edge=1, busy=0; done never asserts.
//  - HP=3, N=5, sys_rst asserted mid-burst, asynchronously between edges ->
//    outputs go to reset values before the next edge; next start yields a clean full 5-period burst.
//  - HP=2, N=1: second start in the done cycle is accepted; start while busy with num_cycles=7 is ignored ->
//    exactly 1+1 periods; bus_clk low >= 2 cycles between bursts.
//  - HP=1, IDLE=1, N=3 -> bus_clk 0,1,0,1,0,1 on T0+1..T0+6.
//    fall_edge at T0+1,3,5; rise_edge at T0+2,4,6; done at T0+6.

Source files
------------

// File: rtl/bus_clock_generator.sv
// ============================================================================
// Module      : bus_clock_generator
// Description : Drives a bus clock synchronous to sys_clk, producing bursts of
//               N full periods with one-cycle rise/fall strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_clock_generator #(
    parameter int HALF_PERIOD = 4,
    parameter bit IDLE_LEVEL  = 1'b0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_cycles,
    input  logic                 abort,
    output logic                 bus_clk,
    output logic                 rise_edge,
    output logic                 fall_edge,
    output logic                 busy,
    output logic                 done
);

    localparam int c_HALF_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [c_HALF_W-1:0] c_HALF_MAX = c_HALF_W'(HALF_PERIOD - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_HALF_W-1:0]    r_half;
    logic [c_HALF_W-1:0]    w_half_nxt;
    logic [CNT_WIDTH:0]     r_tog;
    logic [CNT_WIDTH:0]     w_tog_nxt;
    logic [CNT_WIDTH:0]     w_tog_inc;
    logic [CNT_WIDTH-1:0]   r_num;
    logic [CNT_WIDTH-1:0]   w_num_nxt;
    logic                   w_bus_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;

    assign w_tog_inc = r_tog + 1'b1;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_half    <= '0;
            r_tog     <= '0;
            r_num     <= '0;
            bus_clk   <= IDLE_LEVEL;
            rise_edge <= 1'b0;
            fall_edge <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_half    <= w_half_nxt;
            r_tog     <= w_tog_nxt;
            r_num     <= w_num_nxt;
            bus_clk   <= w_bus_nxt;
            rise_edge <= w_rise_nxt;
            fall_edge <= w_fall_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = r_half;
        w_tog_nxt   = r_tog;
        w_num_nxt   = r_num;
        w_bus_nxt   = bus_clk;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !abort && (num_cycles != '0)) begin
                    w_state_nxt = S_RUN;
                    w_busy_nxt  = 1'b1;
                    w_num_nxt   = num_cycles;
                    w_half_nxt  = '0;
                    w_tog_nxt   = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Forced return to idle still reports the edge it creates
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_bus_nxt   = IDLE_LEVEL;
                    w_half_nxt  = '0;
                    w_tog_nxt   = '0;
                    if (bus_clk != IDLE_LEVEL) begin
                        w_rise_nxt = IDLE_LEVEL;
                        w_fall_nxt = !IDLE_LEVEL;
                    end
                end else if (r_half == c_HALF_MAX) begin
                    w_half_nxt = '0;
                    w_tog_nxt  = w_tog_inc;
                    w_bus_nxt  = ~bus_clk;
                    w_rise_nxt = ~bus_clk;
                    w_fall_nxt = bus_clk;
                    if (w_tog_inc == {r_num, 1'b0}) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_half_nxt = r_half + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_clock_generator.sv
// ============================================================================
// Module      : tb_bus_clock_generator
// Description : Directed self-checking bench for bus_clock_generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_clock_generator;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic [7:0] num_cycles = 8'd0;

    logic bus_a, rise_a, fall_a, busy_a, done_a;
    logic bus_b, rise_b, fall_b, busy_b, done_b;
    logic bus_c, rise_c, fall_c, busy_c, done_c;
    logic bus_d, rise_d, fall_d, busy_d, done_d;

    logic [4:0] w_pa, w_pb, w_pc, w_pd;
    assign w_pa = {bus_a, rise_a, fall_a, busy_a, done_a};
    assign w_pb = {bus_b, rise_b, fall_b, busy_b, done_b};
    assign w_pc = {bus_c, rise_c, fall_c, busy_c, done_c};
    assign w_pd = {bus_d, rise_d, fall_d, busy_d, done_d};

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    bus_clock_generator #(.HALF_PERIOD(2), .IDLE_LEVEL(1'b0), .CNT_WIDTH(8)) u_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .num_cycles(num_cycles),
        .abort(abort), .bus_clk(bus_a), .rise_edge(rise_a), .fall_edge(fall_a),
        .busy(busy_a), .done(done_a));
    bus_clock_generator #(.HALF_PERIOD(4), .IDLE_LEVEL(1'b0), .CNT_WIDTH(8)) u_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .num_cycles(num_cycles),
        .abort(abort), .bus_clk(bus_b), .rise_edge(rise_b), .fall_edge(fall_b),
        .busy(busy_b), .done(done_b));
    bus_clock_generator #(.HALF_PERIOD(3), .IDLE_LEVEL(1'b0), .CNT_WIDTH(8)) u_c (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .num_cycles(num_cycles),
        .abort(abort), .bus_clk(bus_c), .rise_edge(rise_c), .fall_edge(fall_c),
        .busy(busy_c), .done(done_c));
    bus_clock_generator #(.HALF_PERIOD(1), .IDLE_LEVEL(1'b1), .CNT_WIDTH(8)) u_d (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .num_cycles(num_cycles),
        .abort(abort), .bus_clk(bus_d), .rise_edge(rise_d), .fall_edge(fall_d),
        .busy(busy_d), .done(done_d));

    // Packed vectors are {bus_clk, rise_edge, fall_edge, busy, done}
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    // Returns 1 ns after T0, the edge where start is sampled
    task automatic launch(input logic [7:0] n);
        @(negedge sys_clk);
        start      = 1'b1;
        num_cycles = n;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [4:0] pk(input bit b, input bit r, input bit f, input bit bs, input bit d);
        return {b, r, f, bs, d};
    endfunction

    initial begin
        do_reset();
        #1;
        check_val("reset_a", w_pa, 5'b00000);
        check_val("reset_d", w_pd, 5'b10000);

        // HP=2, N=2 basic burst
        launch(8'd2);
        for (int j = 0; j <= 10; j++) begin
            check_val($sformatf("basic_j%0d", j), w_pa,
                pk((j >= 2 && j <= 3) || (j >= 6 && j <= 7), j == 2 || j == 6,
                   j == 4 || j == 8, j <= 7, j == 8));
            step();
        end

        // N=0 request is ignored
        do_reset();
        launch(8'd0);
        for (int j = 0; j < 20; j++) begin
            check_val($sformatf("zero_j%0d", j), w_pa, 5'b00000);
            step();
        end

        // HP=4, N=3, abort while bus_clk high
        do_reset();
        launch(8'd3);
        for (int j = 0; j < 5; j++) step();
        check_val("abort_pre", w_pb, 5'b10010);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("abort_edge", w_pb, 5'b00100);
        for (int j = 0; j < 20; j++) begin
            step();
            check_val($sformatf("abort_after_j%0d", j), w_pb, 5'b00000);
        end

        // HP=3, N=5, asynchronous reset mid-burst then clean burst
        do_reset();
        launch(8'd5);
        for (int j = 0; j < 4; j++) step();
        check_val("rst_pre", w_pc, 5'b10010);
        #2;
        sys_rst = 1'b1;
        #1;
        check_val("rst_async", w_pc, 5'b00000);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        launch(8'd5);
        for (int j = 0; j <= 32; j++) begin
            check_val($sformatf("rst_burst_j%0d", j), w_pc,
                pk(j < 30 && ((j / 3) % 2 == 1), j % 6 == 3 && j < 30,
                   j % 6 == 0 && j > 0 && j <= 30, j <= 29, j == 30));
            step();
        end

        // HP=2, N=1 back-to-back; start while busy ignored
        do_reset();
        launch(8'd1);
        for (int j = 0; j <= 14; j++) begin
            check_val($sformatf("b2b_j%0d", j), w_pa,
                pk(j == 2 || j == 3 || j == 7 || j == 8, j == 2 || j == 7,
                   j == 4 || j == 9, (j <= 3) || (j >= 5 && j <= 8), j == 4 || j == 9));
            if (j == 1) begin
                start      = 1'b1;
                num_cycles = 8'd7;
            end
            if (j == 3) num_cycles = 8'd1;
            if (j == 5) start = 1'b0;
            step();
        end

        // HP=1, IDLE_LEVEL=1, N=3
        do_reset();
        launch(8'd3);
        for (int j = 0; j <= 8; j++) begin
            check_val($sformatf("hp1_j%0d", j), w_pd,
                pk(!(j >= 1 && j <= 6 && (j % 2 == 1)), j >= 2 && j <= 6 && (j % 2 == 0),
                   j >= 1 && j <= 5 && (j % 2 == 1), j <= 5, j == 6));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
